clkdiv_ctrl: RTL
================

Name: clkdiv_ctrl

Overview:
Run/stop and ratio-configuration controller for a programmable integer clock divider.
- Owns the divide counter and produces a divided clock-enable level and a one-cycle tick per output period.
- Accepts new divide ratios over a valid/ready handshake. New ratios, start and stop take effect only at output-period boundaries, so no runt periods occur.
- Sits between the control/register logic and the consumers of divided ticks.

Parameters:
CNT_W, 8, width of the divide ratio and internal counter; legal ratios are 2..2^CNT_W-1
DEF_DIV, 2, divide ratio loaded at reset; must be >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  run request; 1 = run divider, 0 = stop at next period boundary
cfg_valid  input  1  new divide ratio offered
cfg_div  input  CNT_W  offered divide ratio N
cfg_ready  output  1  controller can accept a ratio this cycle
cfg_err  output  1  one-cycle pulse: accepted ratio was illegal (N < 2) and was discarded
div_out  output  1  divided level; high for N>>1 cycles, low for N-(N>>1) cycles per period
tick  output  1  one-cycle pulse at start of each output period
running  output  1  1 while state is RUN
cur_div  output  CNT_W  ratio currently in effect

Behaviour:
- Reset (rst=1 sampled at clk edge): state=IDLE, cnt=0, cur_div=DEF_DIV, pend_valid=0, div_out=0, tick=0, running=0, cfg_ready=1, cfg_err=0. Reset overrides all other inputs, including mid-period and with a pending config.
- State: two-state FSM, IDLE and RUN, plus a pending-config register (pend_div, pend_valid).
- All outputs are registered or are pure functions of registered state (Moore). No input-to-output combinational path except none; cfg_ready = ~pend_valid.
- IDLE:
  - cnt held at 0; div_out=0, tick=0.
  - en=1 sampled → RUN next cycle with cnt=0. tick and div_out assert in that first RUN cycle (1-cycle latency from en).
- RUN:
  - cnt increments each cycle.
  - tick = (cnt==0).
  - div_out = (cnt < cur_div>>1).
  - Boundary = cycle where cnt==cur_div-1. At a boundary, cnt returns to 0.
  - If en=0 at a boundary → IDLE. Stop is never abrupt: en deasserted mid-period completes the current period.
  - If en returns to 1 before the boundary, running continues uninterrupted.
- Config handshake:
  - A transfer occurs when cfg_valid & cfg_ready.
  - cfg_div < 2: cfg_err=1 the next cycle; nothing stored; cur_div unchanged.
  - In IDLE: cur_div <= cfg_div the next cycle; pend_valid stays 0.
  - In RUN:
    - pend_div <= cfg_div and pend_valid <= 1, so cfg_ready=0 until applied.
    - Transfer in the same cycle as a boundary: the value applies at that boundary, i.e. cur_div updates next cycle and pend_valid stays 0.
- Applying pending config:
  - At each boundary with pend_valid=1: cur_div <= pend_div, pend_valid <= 0. The next period uses the new ratio.
  - Stop at a boundary with pend_valid=1: pending value is applied and state goes IDLE.
- cfg_valid held with cfg_ready=0: no transfer; the offered value must be held by the source (standard valid/ready).
- Arithmetic:
  - cnt is CNT_W bits; it never exceeds cur_div-1, so no wrap.
  - Max ratio 2^CNT_W-1.
  - Odd N gives a low phase one cycle longer than the high phase.

Test Plan:
- rst=1 for 2 cycles, then en=0 → cur_div=2, div_out=0, tick=0, running=0, cfg_ready=1 indefinitely.
- DEF_DIV=2, en=1 from cycle 0 → running=1 at cycle 1; tick at cycles 1,3,5…; div_out toggles every cycle (1,0,1,0…).
- In IDLE, cfg_div=5 handshake, then en=1 → period 5: div_out high 2 cycles, low 3; ticks 5 cycles apart.
- While running N=4, offer cfg_div=7 at cnt=1:
  - cfg_ready drops next cycle.
  - Remaining N=4 period completes unchanged.
  - Following ticks are 7 apart.
  - cfg_ready returns 1 the cycle after the boundary.
- cfg_div=1 (and 0) offered → transfer completes, cfg_err pulses 1 cycle, cur_div unchanged, tick spacing unchanged.
- Running N=6, en=0 at cnt=2 → 3 more cycles of the period, then running=0 and div_out=0.
- Repeat with rst=1 at cnt=2 instead → all outputs at reset values the next cycle; pending ratio discarded (cur_div=DEF_DIV).

Source files
------------

// File: rtl/clkdiv_ctrl.sv
// Run/stop and ratio controller for a programmable integer clock divider.
// Ratio changes, start and stop land only on output-period boundaries; all outputs registered.
module clkdiv_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_div
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [CNT_W-1:0] pend_div, nxt_pend_div;
  logic             pend_valid, nxt_pend_valid;
  logic [CNT_W-1:0] nxt_cur_div;
  logic             xfer, bad, good, boundary;

  assign xfer     = cfg_valid & cfg_ready;
  assign bad      = xfer & (cfg_div < TWO);
  assign good     = xfer & ~bad;
  assign boundary = (state == RUN) && (cnt == cur_div - ONE);

  always_comb begin
    nxt_state      = state;
    nxt_cnt        = cnt;
    nxt_cur_div    = cur_div;
    nxt_pend_div   = pend_div;
    nxt_pend_valid = pend_valid;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (good) nxt_cur_div = cfg_div;
        if (en) nxt_state = RUN;
      end
      RUN: begin
        if (boundary) begin
          nxt_cnt = '0;
          // A pending ratio and a same-cycle transfer are exclusive since cfg_ready = ~pend_valid.
          if (pend_valid) begin
            nxt_cur_div    = pend_div;
            nxt_pend_valid = 1'b0;
          end else if (good) begin
            nxt_cur_div = cfg_div;
          end
          if (!en) nxt_state = IDLE;
        end else begin
          nxt_cnt = cnt + ONE;
          if (good) begin
            nxt_pend_div   = cfg_div;
            nxt_pend_valid = 1'b1;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_div    <= DEF;
      pend_div   <= '0;
      pend_valid <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
      div_out    <= 1'b0;
      tick       <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      cur_div    <= nxt_cur_div;
      pend_div   <= nxt_pend_div;
      pend_valid <= nxt_pend_valid;
      cfg_ready  <= ~nxt_pend_valid;
      cfg_err    <= bad;
      running    <= (nxt_state == RUN);
      tick       <= (nxt_state == RUN) && (nxt_cnt == '0);
      div_out    <= (nxt_state == RUN) && (nxt_cnt < (nxt_cur_div >> 1));
    end
  end

endmodule
